fifo_word_serializer: RTL

FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

---
 rtl/fifo_ser_pkg.sv | 15 +
 rtl/fifo_ser_byte_sel.sv | 22 ++
 rtl/fifo_word_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types for the FIFO word serializer: FSM state encoding and byte-index width.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  // Bits needed to address every byte of a WD-bit word (minimum 1).
  function automatic int unsigned idx_width(input int unsigned wd);
    return (wd / 8 > 1) ? $clog2(wd / 8) : 1;
  endfunction

endpackage

// File: rtl/fifo_ser_byte_sel.sv
// Combinational byte multiplexer: picks byte[idx] of a word, byte 0 being the MSB byte.
module fifo_ser_byte_sel
  import fifo_ser_pkg::*;
#(
  parameter int unsigned WD = 256,
  parameter int unsigned IW = idx_width(WD)
) (
  input  logic [WD-1:0] word,
  input  logic [IW-1:0] idx,
  output logic [7:0]    byte_c
);

  localparam int unsigned NB = WD / 8;

  always_comb begin
    byte_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == IW'(i)) byte_c = word[WD-1-8*i -: 8];
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Reads WD-bit words from a FWFT FIFO and emits a length-bounded byte frame, MSB byte first.
// Optional frame/byte statistics counters are built only when FIFO_SER_STATS_EN is defined.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned WD   = 256,
  parameter int unsigned LENW = 16
) (
  input  logic            rd_clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  input  logic [WD-1:0]   fifo_dout,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            tx_last,
  output logic            underrun,
  output logic [31:0]     frame_cnt,
  output logic [31:0]     byte_cnt
);

  localparam int unsigned NB = WD / 8;
  localparam int unsigned IW = idx_width(WD);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [LENW-1:0] remaining_q;
  logic [WD-1:0]   shreg_q;
  logic            first_word_q;
  logic            underrun_q;
  logic            start_ok;
  logic            hs;

  assign start_ok = (state_q == IDLE) && start && (len != '0);
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign underrun = underrun_q;

  // Next-state and handshake-side outputs.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_last  = (remaining_q == LENW'(1));
        if (tx_ready) begin
          if (remaining_q == LENW'(1))  state_d = IDLE;
          else if (idx_q == IW'(NB-1))  state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: word register, byte index, remaining count and underrun tracking.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      idx_q        <= '0;
      remaining_q  <= '0;
      shreg_q      <= '0;
      first_word_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        remaining_q  <= len;
        idx_q        <= '0;
        first_word_q <= 1'b1;
      end
      if (fifo_rd_en) begin
        shreg_q      <= fifo_dout;
        first_word_q <= 1'b0;
      end
      // Waiting on the first word of a frame is normal start-up, not an underrun.
      if ((state_q == FETCH) && fifo_empty && !first_word_q) underrun_q <= 1'b1;
      if (hs) begin
        remaining_q <= remaining_q - LENW'(1);
        idx_q       <= (idx_q == IW'(NB-1)) ? '0 : idx_q + IW'(1);
      end
    end
  end

  fifo_ser_byte_sel #(
    .WD (WD),
    .IW (IW)
  ) u_byte_sel (
    .word   (shreg_q),
    .idx    (idx_q),
    .byte_c (tx_data)
  );

`ifdef FIFO_SER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [31:0] byte_cnt_q;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
    end else if (hs) begin
      byte_cnt_q <= byte_cnt_q + 32'(1);
      if (tx_last) frame_cnt_q <= frame_cnt_q + 32'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign byte_cnt  = byte_cnt_q;
`else
  assign frame_cnt = '0;
  assign byte_cnt  = '0;
`endif

endmodule
